// File: rtl/seven_seg_mux_hex.sv
// seven_seg_mux_hex: time-multiplexed hex driver for a NUM_DIGITS-digit seven-segment display
//   clk          system clock
//   resetn       asynchronous active-low reset
//   value_in     packed hex value, nibble k shown on digit k (nibble 0 = rightmost digit)
//   dp_in        per-digit decimal point, 1 = lit
//   digit_en_in  per-digit enable, 1 = digit may be shown
//   lz_en        leading-zero suppression enable
//   segout       bit0..6 = segments a..g, bit7 = dp, polarity set by SEG_ACTIVE_LOW
//   digsel       one-hot digit select, polarity set by DIG_ACTIVE_LOW
//   frame_tick   one-cycle pulse when the input snapshot is taken
module seven_seg_mux_hex #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    lz_en,
  output logic [7:0]              segout,
  output logic [NUM_DIGITS-1:0]   digsel,
  output logic                    frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  // XOR with the idle level turns a lit-high pattern into the pin polarity
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] value_sh;
  logic [NUM_DIGITS-1:0] dp_sh, en_sh;
  logic lz_sh;
  logic slot_end, frame_end, nz_above, suppress, vis;
  logic [3:0] nib;
  logic [6:0] glyph;
  assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign nib       = 4'(value_sh >> {idx, 2'b00});
  // a digit counts as nonzero only while it is enabled, so disabled digits never hold zeros on
  always_comb begin
    nz_above = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      nz_above = nz_above | (k >= int'(idx) && en_sh[k] && value_sh[4*k +: 4] != 4'h0);
  end
  assign suppress = lz_sh && idx != '0 && !nz_above;
  assign vis      = en_sh[idx] && cnt >= CW'(BLANK_CYCLES) && !suppress;
  // lit-high g..a; unknown nibbles fall to the default bar pattern
  always_comb
    case (nib)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1100111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      4'hF: glyph = 7'b1110001;
      default: glyph = 7'b1001001;
    endcase
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt        <= '0;
      idx        <= '0;
      value_sh   <= '0;
      dp_sh      <= '0;
      en_sh      <= '0;
      lz_sh      <= 1'b0;
      frame_tick <= 1'b0;
      segout     <= SEG_OFF;
      digsel     <= DIG_OFF;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
      if (frame_end) begin
        value_sh <= value_in;
        dp_sh    <= dp_in;
        en_sh    <= digit_en_in;
        lz_sh    <= lz_en;
      end
      frame_tick <= frame_end;
      segout     <= vis ? SEG_OFF ^ {dp_sh[idx], glyph} : SEG_OFF;
      digsel     <= vis ? DIG_OFF ^ (NUM_DIGITS'(1) << idx) : DIG_OFF;
    end
endmodule

// File: tb/tb_seven_seg_mux_hex.sv
// tb_seven_seg_mux_hex: scoreboard bench driving an active-low and an active-high instance side by side
module tb_seven_seg_mux_hex;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = N * RD;
  typedef struct packed { logic [7:0] seg; logic [3:0] dig; logic tick; } exp_t;
  logic clk = 1'b0, resetn = 1'b0, lz_en = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0, digit_en_in = '0;
  logic [7:0] seg_lo, seg_hi;
  logic [3:0] dig_lo, dig_hi;
  logic tick_lo, tick_hi;
  int n_checks = 0, n_fail = 0;
  exp_t exp_q[$];
  logic [6:0] lut [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  always #5 clk = ~clk;
  seven_seg_mux_hex #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .resetn(resetn), .value_in(value_in), .dp_in(dp_in),
    .digit_en_in(digit_en_in), .lz_en(lz_en),
    .segout(seg_lo), .digsel(dig_lo), .frame_tick(tick_lo));
  seven_seg_mux_hex #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL),
                      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .resetn(resetn), .value_in(value_in), .dp_in(dp_in),
    .digit_en_in(digit_en_in), .lz_en(lz_en),
    .segout(seg_hi), .digsel(dig_hi), .frame_tick(tick_hi));
  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endfunction
  // reference model: c = clock edges since reset release; slot/phase and frame come from plain division
  int c = 0;
  logic [15:0] sv = '0, live;
  logic [3:0] sdp = '0, sen = '0;
  logic slz = 1'b0;
  initial forever begin
    exp_t e;
    int slot, ph;
    logic shown;
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      c = 0; sv = '0; sdp = '0; sen = '0; slz = 1'b0;
      exp_q.delete();
    end else begin
      ph = c % RD;
      slot = (c / RD) % N;
      live = '0;
      for (int k = 0; k < N; k++) if (sen[k]) live = live | (sv & (16'hF << (4 * k)));
      shown = sen[slot] && ph >= BL && !(slz && slot > 0 && (live >> (4 * slot)) == 16'h0);
      e.seg = shown ? {sdp[slot], lut[4'(sv >> (4 * slot))]} : 8'h00;
      e.dig = shown ? 4'(1 << slot) : 4'h0;
      e.tick = (c + 1) % FR == 0;
      exp_q.push_back(e);
      c++;
      if (c % FR == 0) begin
        sv = value_in; sdp = dp_in; sen = digit_en_in; slz = lz_en;
      end
    end
  end
  // monitor: one expected entry per clock; with nothing pending both instances must sit idle
  initial forever begin
    exp_t e;
    @(negedge clk);
    e = (resetn && exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_lo", {seg_lo, dig_lo, tick_lo}, {~e.seg, ~e.dig, e.tick});
    check("out_hi", {seg_hi, dig_hi, tick_hi}, {e.seg, e.dig, e.tick});
  end
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic apply(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en, input logic lz);
    value_in = v; dp_in = dp; digit_en_in = en; lz_en = lz;
  endtask
  task automatic wait_tick(input int want, input bit do_check);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tick_lo && n < 3 * FR);
    if (do_check) check("first_tick_cycle", n, want);
    else if (!tick_lo) check("tick_timeout", 0, 1);
  endtask
  initial begin
    apply(16'h12AF, 4'h0, 4'hF, 1'b1);
    run(5);
    resetn = 1'b1;
    wait_tick(FR, 1'b1);
    run(2 * FR);
    apply(16'h0050, 4'h0, 4'hF, 1'b1);
    run(2 * FR);
    apply(16'h0000, 4'h0, 4'hF, 1'b1);
    run(2 * FR);
    apply(16'h0000, 4'h0, 4'hF, 1'b0);
    run(2 * FR);
    apply(16'h1111, 4'h0, 4'hF, 1'b0);
    wait_tick(0, 1'b0);
    wait_tick(0, 1'b0);
    run(10);
    value_in = 16'h2222;
    run(2 * FR);
    dp_in = 4'b0100;
    run(2 * FR);
    apply(16'h1234, 4'h0, 4'b1010, 1'b1);
    run(2 * FR);
    apply(16'h0008, 4'h0, 4'hF, 1'b0);
    run(2 * FR);
    begin
      int n = 0;
      while (c % FR != 2 * RD + 5 && n < 2 * FR) begin @(negedge clk); n++; end
      check("reach_idx2_cnt5", c % FR, 2 * RD + 5);
    end
    #2 resetn = 1'b0;
    #1;
    check("async_rst_lo", {seg_lo, dig_lo, tick_lo}, {8'hFF, 4'hF, 1'b0});
    check("async_rst_hi", {seg_hi, dig_hi, tick_hi}, {8'h00, 4'h0, 1'b0});
    run(5);
    apply(16'h12AF, 4'h0, 4'hF, 1'b1);
    resetn = 1'b1;
    wait_tick(FR, 1'b1);
    run(FR);
    for (int i = 0; i < 40; i++) begin
      apply(16'($urandom & ((($urandom & 1) != 0) ? 32'hFFFF : 32'h00FF)),
            4'($urandom), 4'($urandom | (($urandom & 1) != 0 ? 32'hF : 32'h0)),
            1'($urandom));
      run($urandom_range(1, 40));
    end
    run(2 * FR);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_mux_hex.md
Name: seven_seg_mux_hex

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-select seven-segment display.
- Decodes a packed hex value one nibble per digit and adds a per-digit decimal point, per-digit enable and leading-zero suppression.
- Inter-digit blanking prevents ghosting; inputs are snapshotted once per frame so the display never tears.
- Sits between user logic (counters, debug registers) and the board segment/digit pins.

Parameters:
- NUM_DIGITS, 4, digits driven (1..8).
- REFRESH_DIV, 1024, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (0..REFRESH_DIV-1).
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: lit = 1.
- DIG_ACTIVE_LOW, 1, 1: digit selected = 0; 0: selected = 1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- value_in  in  4*NUM_DIGITS  hex value; nibble k displayed on digit k (nibble 0 = least-significant digit).
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en_in  in  NUM_DIGITS  1 = digit may be shown.
- lz_en  in  1  leading-zero suppression enable.
- segout  out  8  bit0..6 = segments a..g, bit7 = dp; polarity per SEG_ACTIVE_LOW.
- digsel  out  NUM_DIGITS  one-hot digit select; polarity per DIG_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse at each frame boundary (snapshot taken).

Behaviour:
- Decided: one clock; reset is asynchronous and active-low.
- State registers:
  - cnt: 0..REFRESH_DIV-1.
  - idx: 0..NUM_DIGITS-1.
  - Shadow registers: value, dp, digit_en, lz_en.
- Reset (resetn=0, async): cnt=0, idx=0, all shadows 0, frame_tick=0, segout all-off (8'hFF when SEG_ACTIVE_LOW), digsel all-inactive. Holds for as long as resetn=0. Reset mid-frame discards the frame.
- Counting: cnt increments every clk. At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances.
- Frame boundary: idx=NUM_DIGITS-1 at cnt wrap. On that edge idx wraps to 0, all shadows capture their inputs, and frame_tick=1 for exactly one cycle.
- Mid-frame input changes have no visible effect until the next boundary.
- After reset the shadows are 0, so nothing is displayed until the first boundary, NUM_DIGITS*REFRESH_DIV cycles after reset release.
- Visibility of digit idx: shadow digit_en[idx]=1, cnt>=BLANK_CYCLES, and the digit is not lz-suppressed.
- Leading-zero suppression (shadow lz_en=1): digit k>0 is suppressed iff the nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed. Disabled digits do not count as nonzero.
- Decode, lit-high form g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Non-0/1 (X/Z) nibble in simulation: 1001001.
  - bit7 = shadow dp[idx].
  - The result is inverted when SEG_ACTIVE_LOW.
- Outputs are registered: segout, digsel and frame_tick reflect the cnt/idx/shadow state one cycle earlier. No combinational input-to-output path.
- When no digit is visible, segout is all-off and digsel is all-inactive.
- digsel is never more than one-hot active.

Test Plan:
- Default parameters except NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, both polarities active-low.
- Reset: hold resetn=0 for 5 cycles, then release with value_in=16'h12AF and all enables 1.
  - During reset and for the first 32 cycles: segout=8'hFF, digsel=4'hF.
  - frame_tick pulses on cycle 32 after release.
- Decode/scan: after the first boundary, each 8-cycle slot shows digit0 8'h8E (F), digit1 8'h88 (A), digit2 8'hA4 (2), digit3 8'hF9 (1).
  - digsel=4'hE/D/B/7 respectively, active for the last 6 cycles of each slot (one-cycle output lag).
  - digsel=4'hF during the 2 blank cycles.
- Leading zeros: value_in=16'h0050, lz_en=1.
  - digits 3 and 2 stay inactive; digit1 shows 8'h92; digit0 shows 8'hC0.
  - value_in=0: only digit0 is shown, 8'hC0.
  - lz_en=0: all four digits show 8'hC0.
- Tear-free and decimal point:
  - Change value_in mid-frame from 16'h1111 to 16'h2222: the remainder of the frame still shows 8'hF9; 8'hA4 appears only after the next frame_tick.
  - dp_in=4'b0100: digit2 segout bit7=0, all other digits bit7=1.
- Digit enable and async reset:
  - digit_en_in=4'b1010: digsel never selects digits 0 or 2.
  - Drop resetn at idx=2, cnt=5: outputs go to 8'hFF/4'hF immediately (no clock edge needed); after release, the sequence restarts from the Reset scenario.
- Polarity: SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0, value 8 on digit0.
  - segout=8'h7F, digsel=4'b0001 during visible cycles.
  - segout=8'h00, digsel=4'b0000 while blank.
